// File: rtl/pc_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pc_ctrl_pkg : shared state encoding and constants for pc_ctrl         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam int unsigned c_START_ADDR = 0;
  localparam int unsigned c_CNT_W      = 16;

endpackage

`default_nettype wire

// File: rtl/pc_ctrl.sv
// +----------------------------------------------------------------------+
// | pc_ctrl : program counter sequencer with halt/jump/branch/stall      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned PW         = 10,
  parameter int unsigned START_ADDR = c_START_ADDR
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Halt,
  input  logic               JumpEn,
  input  logic               BranchEn,
  input  logic               BranchFlag,
  input  logic [PW-1:0]      Target,
  input  logic               Stall,
  output logic [PW-1:0]      ProgCtr,
  output logic               Fetch,
  output logic               Busy,
  output logic               Done,
  output logic [c_CNT_W-1:0] InstrCnt
);

  localparam logic [PW-1:0]      c_START_PC = PW'(START_ADDR);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

  pc_state_t     r_state;
  logic [PW-1:0] w_next_pc;

  // Halt keeps the PC on the halt instruction; increment wraps naturally.
  always_comb begin
    w_next_pc = ProgCtr + PW'(1);
    if (Halt) begin
      w_next_pc = ProgCtr;
    end else if (JumpEn || (BranchEn && BranchFlag)) begin
      w_next_pc = Target;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      ProgCtr  <= c_START_PC;
      Fetch    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      InstrCnt <= '0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (Start) begin
            r_state  <= RUN;
            ProgCtr  <= c_START_PC;
            Fetch    <= 1'b1;
            Busy     <= 1'b1;
            Done     <= 1'b0;
            InstrCnt <= '0;
          end
        end
        RUN: begin
          if (!Stall) begin
            ProgCtr <= w_next_pc;
            if (InstrCnt != c_CNT_MAX) begin
              InstrCnt <= InstrCnt + c_CNT_W'(1);
            end
            if (Halt) begin
              r_state <= HALTED;
              Fetch   <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          ProgCtr  <= c_START_PC;
          Fetch    <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b0;
          InstrCnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pc_ctrl : table vectors, corner sequences and random vs. model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pc_ctrl;

  typedef struct {
    logic       rst, st, hl, jp, br, fl;
    logic [9:0] tg;
    logic       sl;
    int         pc;
    logic       f, b, d;
    int         c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, halt = 1'b0, jump = 1'b0;
  logic        br = 1'b0, flag = 1'b0, stall = 1'b0;
  logic [9:0]  target = '0;

  logic [9:0]  pc10;
  logic        f10, b10, d10;
  logic [15:0] cnt10;
  logic [3:0]  pc4;
  logic        f4, b4, d4;
  logic [15:0] cnt4;

  int tests = 0;
  int fails = 0;

  // Reference state per instance: index 0 is PW=10, index 1 is PW=4.
  int m_pw  [2] = '{10, 4};
  bit m_run [2];
  bit m_hlt [2];
  int m_pc  [2];
  int m_cnt [2];

  vec_t vq[$];

  pc_ctrl #(.PW(10)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .JumpEn(jump),
    .BranchEn(br), .BranchFlag(flag), .Target(target), .Stall(stall),
    .ProgCtr(pc10), .Fetch(f10), .Busy(b10), .Done(d10), .InstrCnt(cnt10)
  );

  pc_ctrl #(.PW(4)) dut4 (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .JumpEn(jump),
    .BranchEn(br), .BranchFlag(flag), .Target(target[3:0]), .Stall(stall),
    .ProgCtr(pc4), .Fetch(f4), .Busy(b4), .Done(d4), .InstrCnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mask;
      mask = (1 << m_pw[k]) - 1;
      if (rst) begin
        m_run[k] = 0; m_hlt[k] = 0; m_pc[k] = 0; m_cnt[k] = 0;
      end else if (m_run[k]) begin
        if (!stall) begin
          m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
          if (halt) begin
            m_run[k] = 0; m_hlt[k] = 1;
          end else if (jump || (br && flag)) begin
            m_pc[k] = int'(target) & mask;
          end else begin
            m_pc[k] = (m_pc[k] + 1) & mask;
          end
        end
      end else if (start) begin
        m_run[k] = 1; m_hlt[k] = 0; m_pc[k] = 0; m_cnt[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, s, h, j, b, fl, input logic [9:0] t, input logic sl);
    rst = r; start = s; halt = h; jump = j; br = b; flag = fl; target = t; stall = sl;
  endtask

  task automatic chk(input string nm, input int gpc, input logic gf, gb, gd, input int gc,
                     input int epc, input logic ef, eb, ed, input int ec);
    tests++;
    if (gpc !== epc || gf !== ef || gb !== eb || gd !== ed || gc !== ec) begin
      fails++;
      $display("FAIL %s: got pc=%0d fetch=%b busy=%b done=%b cnt=%0d, want pc=%0d fetch=%b busy=%b done=%b cnt=%0d",
               nm, gpc, gf, gb, gd, gc, epc, ef, eb, ed, ec);
    end
  endtask

  task automatic add(input logic r, s, h, j, b, fl, input logic [9:0] t, input logic sl,
                     input int pc, input logic f, bz, d, input int c);
    vec_t v;
    v.rst = r; v.st = s; v.hl = h; v.jp = j; v.br = b; v.fl = fl; v.tg = t; v.sl = sl;
    v.pc = pc; v.f = f; v.b = bz; v.d = d; v.c = c;
    vq.push_back(v);
  endtask

  // Reset, Start, then n plain retiring cycles.
  task automatic add_run(input int n);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, i, 1, 1, 0, i);
  endtask

  initial begin
    // Sequential run, no auto-start after reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, i, 1, 1, 0, i);
    // Taken branch, then BranchFlag alone ignored
    add_run(3);
    add(0, 0, 0, 0, 1, 1, 40, 0, 40, 1, 1, 0, 4);
    add(0, 0, 0, 0, 0, 1, 7, 0, 41, 1, 1, 0, 5);
    // Branch not taken
    add_run(3);
    add(0, 0, 0, 0, 1, 0, 40, 0, 4, 1, 1, 0, 4);
    // Halt beats jump; HALTED ignores control; Start restarts
    add_run(7);
    add(0, 0, 1, 1, 0, 0, 99, 0, 7, 0, 0, 1, 8);
    add(0, 0, 1, 1, 1, 1, 99, 1, 7, 0, 0, 1, 8);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // Stall holds and masks jump; Start ignored in RUN
    add_run(2);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 50, 1, 2, 1, 1, 0, 2);
    add(0, 0, 0, 1, 0, 0, 50, 0, 50, 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 51, 1, 1, 0, 4);
    // Reset at PC=12 during stall; Start needed to resume
    add(0, 0, 0, 1, 0, 0, 12, 0, 12, 1, 1, 0, 5);
    add(1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 1, 33, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);

    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].st, vq[i].hl, vq[i].jp, vq[i].br, vq[i].fl, vq[i].tg, vq[i].sl);
      tick();
      chk($sformatf("vec%0d", i), int'(pc10), f10, b10, d10, int'(cnt10),
          vq[i].pc, vq[i].f, vq[i].b, vq[i].d, vq[i].c);
    end

    // Wrap at PW=4, then halt and restart
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("w4_reset", int'(pc4), f4, b4, d4, int'(cnt4), 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("w4_start", int'(pc4), f4, b4, d4, int'(cnt4), 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("w4_pc15", int'(pc4), f4, b4, d4, int'(cnt4), 15, 1, 1, 0, 15);
    tick();
    chk("w4_wrap", int'(pc4), f4, b4, d4, int'(cnt4), 0, 1, 1, 0, 16);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("w4_halt", int'(pc4), f4, b4, d4, int'(cnt4), 0, 0, 0, 1, 17);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("w4_restart", int'(pc4), f4, b4, d4, int'(cnt4), 0, 1, 1, 0, 0);

    // Counter saturation
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_reach", int'(pc10), f10, b10, d10, int'(cnt10), 1023, 1, 1, 0, 65535);
    tick(); tick();
    chk("sat_hold", int'(pc10), f10, b10, d10, int'(cnt10), 1, 1, 1, 0, 65535);

    // Random stimulus against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            10'($urandom), $urandom_range(0, 3) == 0);
      tick();
      chk($sformatf("rnd10_%0d", i), int'(pc10), f10, b10, d10, int'(cnt10),
          m_pc[0], m_run[0], m_run[0], m_hlt[0], m_cnt[0]);
      chk($sformatf("rnd4_%0d", i), int'(pc4), f4, b4, d4, int'(cnt4),
          m_pc[1], m_run[1], m_run[1], m_hlt[1], m_cnt[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter PW, default 10, meaning program counter width in bits.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning the PC value loaded on every program start.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, request to begin program execution.
REQ-006 SHALL have port Halt, input, 1, decoded halt instruction at the current PC.
REQ-007 SHALL have port JumpEn, input, 1, decoded unconditional jump at the current PC.
REQ-008 SHALL have port BranchEn, input, 1, decoded conditional branch (BGE/BNE/BEQ) at the current PC.
REQ-009 SHALL have port BranchFlag, input, 1, ALU branch-taken flag for the current instruction.
REQ-010 SHALL have port Target, input, PW, absolute jump/branch target address.
REQ-011 SHALL have port Stall, input, 1, hold request; the current instruction does not retire this cycle.
REQ-012 SHALL have port ProgCtr, output, PW, current instruction address.
REQ-013 SHALL have port Fetch, output, 1, high when ProgCtr holds a valid instruction being executed.
REQ-014 SHALL have port Busy, output, 1, high while in RUN.
REQ-015 SHALL have port Done, output, 1, level-high while in HALTED.
REQ-016 SHALL have port InstrCnt, output, 16, count of retired instructions in the current run.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, HALTED.
REQ-018 SHALL transition IDLE->RUN on Start=1; the cycle after Start, ProgCtr=START_ADDR, Fetch=1, InstrCnt=0.
REQ-019 SHALL drive Fetch=Busy=1 only in RUN; Done=1 only in HALTED; all other outputs registered.
REQ-020 SHALL, in RUN with Stall=0, retire the instruction at ProgCtr and increment InstrCnt by 1.
REQ-021 SHALL select the next PC in RUN with Stall=0 using the priority Halt > JumpEn > (BranchEn & BranchFlag) > ProgCtr+1.
REQ-022 SHALL, on Halt, move to HALTED with ProgCtr held at the halt address; the halt itself counts as retired.
REQ-023 SHALL load Target on JumpEn, or on BranchEn with BranchFlag=1; BranchEn with BranchFlag=0 yields ProgCtr+1.
REQ-024 SHALL ignore BranchFlag when BranchEn=0.
REQ-025 SHALL, in RUN with Stall=1, hold ProgCtr and InstrCnt and ignore Halt, JumpEn, BranchEn and BranchFlag.
REQ-026 SHALL compute ProgCtr+1 modulo 2^PW, so that all-ones wraps to 0 with no flag.
REQ-027 SHALL saturate InstrCnt at 16'hFFFF.
REQ-028 SHALL ignore Start while in RUN.
REQ-029 SHALL, in HALTED, on Start=1 re-enter RUN at START_ADDR with InstrCnt cleared to 0; otherwise hold all outputs.
REQ-030 SHALL sample Halt, JumpEn, BranchEn, BranchFlag, Target and Stall only in RUN.

Reset
REQ-031 SHALL, on Reset=1 at a clock edge, enter IDLE with ProgCtr=START_ADDR, Fetch=0, Busy=0, Done=0, InstrCnt=0.
REQ-032 SHALL give Reset priority over Start and all other inputs, including mid-RUN and mid-Stall.
REQ-033 SHALL require Start after Reset release before execution resumes; there is no auto-start.

Structure
REQ-034 SHALL declare the FSM state enum (pc_state_t: IDLE, RUN, HALTED) in the shared definitions package.
REQ-035 SHALL place START_ADDR's default value in the definitions package as a constant.
REQ-036 SHALL be a single module with no sub-modules; next-PC selection is an always_comb block, state is an always_ff block.

Verification
REQ-037 SHALL cover sequential run: Reset, Start, 5 cycles with no control inputs -> ProgCtr 0,1,2,3,4, InstrCnt=5, Fetch=1.
REQ-038 SHALL cover a taken branch: at PC=3, BranchEn=1, BranchFlag=1, Target=40 -> next ProgCtr=40; the same with BranchFlag=0 -> next ProgCtr=4.
REQ-039 SHALL cover priority: at PC=7, Halt=1 with JumpEn=1 and Target=99 -> HALTED, ProgCtr=7, Done=1, Busy=0, InstrCnt=8.
REQ-040 SHALL cover stall: at PC=2, Stall=1 for 3 cycles with JumpEn=1 -> ProgCtr stays 2 and InstrCnt is unchanged; then Stall=0 -> jump taken.
REQ-041 SHALL cover wrap and restart: PW=4, run from 0 to PC=15 -> next PC=0; then Halt, then Start -> ProgCtr=0, InstrCnt=0, Busy=1.
REQ-042 SHALL cover reset mid-run: Reset=1 at PC=12 during Stall -> the next cycle is IDLE, ProgCtr=0, InstrCnt=0, and Start is required to resume.
